hazard_forwarding_unit: RTL and testbench

HAZARD_FORWARDING_UNIT -- requirements
Module: hazard_forwarding_unit

---
 rtl/hazard_forwarding_unit_if.sv | 50 +++++
 rtl/hazard_forwarding_unit.sv | 129 ++++++++++++
 tb/tb_hazard_forwarding_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forwarding_unit_if.sv
// Hazard/forwarding unit signal bundle: ID/EX/MEM/WB pipeline status in,
// stall, hold, flush and operand-forwarding controls out.
interface hazard_forwarding_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_mdu;
  logic             id_reads_hilo;
  logic [4:0]       WriteDestination_EX;
  logic [4:0]       WriteDestination_MEM;
  logic [4:0]       WriteDestination_WB;
  logic             ex_reg_write;
  logic             mem_reg_write;
  logic             wb_reg_write;
  logic             ex_load;
  logic             mdu_start_EX;
  logic             branch_taken_ID;
  logic             mem_busy;
  logic             pc_le;
  logic             ifid_le;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             mdu_busy;
  logic             mdu_err;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  rs_ID, rt_ID, id_uses_rs, id_uses_rt, id_mdu, id_reads_hilo,
           WriteDestination_EX, WriteDestination_MEM, WriteDestination_WB,
           ex_reg_write, mem_reg_write, wb_reg_write, ex_load,
           mdu_start_EX, branch_taken_ID, mem_busy,
    output pc_le, ifid_le, ifid_flush, idex_bubble, pipe_hold,
           fwd_a_sel, fwd_b_sel, mdu_busy, mdu_err, stall_cnt
  );

  modport master (
    output rs_ID, rt_ID, id_uses_rs, id_uses_rt, id_mdu, id_reads_hilo,
           WriteDestination_EX, WriteDestination_MEM, WriteDestination_WB,
           ex_reg_write, mem_reg_write, wb_reg_write, ex_load,
           mdu_start_EX, branch_taken_ID, mem_busy,
    input  pc_le, ifid_le, ifid_flush, idex_bubble, pipe_hold,
           fwd_a_sel, fwd_b_sel, mdu_busy, mdu_err, stall_cnt
  );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Pipeline hazard detection and operand forwarding for a 5-stage MIPS-style
// core, with a small FSM tracking occupancy of the multi-cycle mult/div unit.
module hazard_forwarding_unit #(
  parameter int MDU_LAT    = 4,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  hazard_forwarding_unit_if.slave bus
);

  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  localparam logic [3:0] MDU_CNT_INIT = 4'(MDU_LAT - 1);

  state_t           state_q;
  logic [3:0]       mdu_cnt_q;
  logic             mdu_err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic busy;
  logic load_use;
  logic mdu_haz;
  logic pc_le, ifid_le, ifid_flush, idex_bubble, pipe_hold;
  logic [1:0] fwd_a, fwd_b;

  // A stage supplies an operand only if it writes a non-zero register equal to the source.
  function automatic logic stage_hit(input logic we, input logic [4:0] dst,
                                     input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  // Youngest producer wins; a load still in EX has no data yet, so it is skipped.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (stage_hit(bus.ex_reg_write && !bus.ex_load, bus.WriteDestination_EX, src))
      return 2'b01;
    else if (stage_hit(bus.mem_reg_write, bus.WriteDestination_MEM, src))
      return 2'b10;
    else if (stage_hit(bus.wb_reg_write, bus.WriteDestination_WB, src))
      return 2'b11;
    else
      return 2'b00;
  endfunction

  assign busy = (state_q == MDU_BUSY);

  assign load_use = bus.ex_load && bus.ex_reg_write && (bus.WriteDestination_EX != 5'd0) &&
                    ((bus.id_uses_rs && (bus.rs_ID == bus.WriteDestination_EX)) ||
                     (bus.id_uses_rt && (bus.rt_ID == bus.WriteDestination_EX)));

  assign mdu_haz = (bus.id_mdu || bus.id_reads_hilo) && (busy || bus.mdu_start_EX);

  // Stall/hold/flush priority: memory wait freezes everything, then ID hazards, then normal flow.
  always_comb begin
    pc_le       = 1'b0;
    ifid_le     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (reset) begin
      fwd_a = fwd_sel(bus.rs_ID);
      fwd_b = fwd_sel(bus.rt_ID);
      if (bus.mem_busy) begin
        pipe_hold = 1'b1;
      end else if (load_use || mdu_haz) begin
        idex_bubble = 1'b1;
      end else begin
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        ifid_flush = (DELAY_SLOT == 0) && bus.branch_taken_ID;
      end
    end
  end

  // MDU occupancy FSM: busy for MDU_LAT cycles after a start; a start while busy is a protocol error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      mdu_cnt_q <= 4'd0;
      mdu_err_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.mdu_start_EX && !pipe_hold) begin
            state_q   <= MDU_BUSY;
            mdu_cnt_q <= MDU_CNT_INIT;
          end
        end
        MDU_BUSY: begin
          if (bus.mdu_start_EX) mdu_err_q <= 1'b1;
          if (mdu_cnt_q == 4'd0) begin
            state_q <= RUN;
          end else begin
            mdu_cnt_q <= mdu_cnt_q - 4'd1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_le && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.pc_le       = pc_le;
  assign bus.ifid_le     = ifid_le;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.pipe_hold   = pipe_hold;
  assign bus.fwd_a_sel   = fwd_a;
  assign bus.fwd_b_sel   = fwd_b;
  assign bus.mdu_busy    = busy;
  assign bus.mdu_err     = mdu_err_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Bench for hazard_forwarding_unit: two instances (delay slot kept / flushed,
// wide / narrow stall counter) driven by the same directed vectors.
module tb_hazard_forwarding_unit;
  localparam int MDU_LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] rs_ID, rt_ID, WriteDestination_EX, WriteDestination_MEM, WriteDestination_WB;
  logic id_uses_rs, id_uses_rt, id_mdu, id_reads_hilo;
  logic ex_reg_write, mem_reg_write, wb_reg_write, ex_load;
  logic mdu_start_EX, branch_taken_ID, mem_busy;

  hazard_forwarding_unit_if #(.CNT_W(3))  if0 ();
  hazard_forwarding_unit_if #(.CNT_W(16)) if1 ();

  assign if0.rs_ID = rs_ID;                 assign if1.rs_ID = rs_ID;
  assign if0.rt_ID = rt_ID;                 assign if1.rt_ID = rt_ID;
  assign if0.id_uses_rs = id_uses_rs;       assign if1.id_uses_rs = id_uses_rs;
  assign if0.id_uses_rt = id_uses_rt;       assign if1.id_uses_rt = id_uses_rt;
  assign if0.id_mdu = id_mdu;               assign if1.id_mdu = id_mdu;
  assign if0.id_reads_hilo = id_reads_hilo; assign if1.id_reads_hilo = id_reads_hilo;
  assign if0.WriteDestination_EX = WriteDestination_EX;   assign if1.WriteDestination_EX = WriteDestination_EX;
  assign if0.WriteDestination_MEM = WriteDestination_MEM; assign if1.WriteDestination_MEM = WriteDestination_MEM;
  assign if0.WriteDestination_WB = WriteDestination_WB;   assign if1.WriteDestination_WB = WriteDestination_WB;
  assign if0.ex_reg_write = ex_reg_write;   assign if1.ex_reg_write = ex_reg_write;
  assign if0.mem_reg_write = mem_reg_write; assign if1.mem_reg_write = mem_reg_write;
  assign if0.wb_reg_write = wb_reg_write;   assign if1.wb_reg_write = wb_reg_write;
  assign if0.ex_load = ex_load;             assign if1.ex_load = ex_load;
  assign if0.mdu_start_EX = mdu_start_EX;   assign if1.mdu_start_EX = mdu_start_EX;
  assign if0.branch_taken_ID = branch_taken_ID; assign if1.branch_taken_ID = branch_taken_ID;
  assign if0.mem_busy = mem_busy;           assign if1.mem_busy = mem_busy;

  hazard_forwarding_unit #(.MDU_LAT(MDU_LAT), .DELAY_SLOT(0), .CNT_W(3))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  hazard_forwarding_unit #(.MDU_LAT(MDU_LAT), .DELAY_SLOT(1), .CNT_W(16))
    dut1 (.clk(clk), .reset(reset), .bus(if1));

  int nvec = 0;
  int nerr = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic pc_le, ifid_le, ifid_flush, idex_bubble, pipe_hold;
    logic [1:0] fa, fb;
    logic busy, err;
  } out_t;

  int m_left [2];   // remaining MDU busy cycles
  logic m_err [2];
  int m_scnt [2];

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (ex_reg_write && !ex_load && WriteDestination_EX == src) return 2'b01;
    if (mem_reg_write && WriteDestination_MEM == src) return 2'b10;
    if (wb_reg_write && WriteDestination_WB == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic out_t model_eval(input int k);
    out_t o;
    logic lu, mh;
    o = '0;
    if (reset !== 1'b1) return o;
    lu = ex_load && ex_reg_write && WriteDestination_EX != 0 &&
         ((id_uses_rs && rs_ID == WriteDestination_EX) || (id_uses_rt && rt_ID == WriteDestination_EX));
    mh = (id_mdu || id_reads_hilo) && (m_left[k] > 0 || mdu_start_EX);
    if (mem_busy) o.pipe_hold = 1'b1;
    else if (lu || mh) o.idex_bubble = 1'b1;
    else begin
      o.pc_le = 1'b1;
      o.ifid_le = 1'b1;
      o.ifid_flush = (k == 0) && branch_taken_ID;
    end
    o.fa = m_fwd(rs_ID);
    o.fb = m_fwd(rt_ID);
    o.busy = m_left[k] > 0;
    o.err = m_err[k];
    return o;
  endfunction

  function automatic int next_scnt(input int k);
    out_t o;
    int mx;
    o = model_eval(k);
    mx = (k == 0) ? 7 : 65535;
    if (!o.pc_le && m_scnt[k] < mx) return m_scnt[k] + 1;
    return m_scnt[k];
  endfunction

  function automatic int next_left(input int k);
    if (m_left[k] > 0) return m_left[k] - 1;
    if (mdu_start_EX && !mem_busy) return MDU_LAT;
    return 0;
  endfunction

  function automatic logic next_err(input int k);
    return m_err[k] || (m_left[k] > 0 && mdu_start_EX);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] <= 0; m_err[k] <= 1'b0; m_scnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_scnt[k] <= next_scnt(k);
        m_left[k] <= next_left(k);
        m_err[k]  <= next_err(k);
      end
    end
  end

  function automatic out_t act_of(input int k);
    if (k == 0)
      return {if0.pc_le, if0.ifid_le, if0.ifid_flush, if0.idex_bubble, if0.pipe_hold,
              if0.fwd_a_sel, if0.fwd_b_sel, if0.mdu_busy, if0.mdu_err};
    return {if1.pc_le, if1.ifid_le, if1.ifid_flush, if1.idex_bubble, if1.pipe_hold,
            if1.fwd_a_sel, if1.fwd_b_sel, if1.mdu_busy, if1.mdu_err};
  endfunction

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      out_t a, e;
      string p;
      a = act_of(k);
      e = model_eval(k);
      p = (k == 0) ? "dut0" : "dut1";
      cmp({p, ".pc_le"},       32'(a.pc_le),       32'(e.pc_le));
      cmp({p, ".ifid_le"},     32'(a.ifid_le),     32'(e.ifid_le));
      cmp({p, ".ifid_flush"},  32'(a.ifid_flush),  32'(e.ifid_flush));
      cmp({p, ".idex_bubble"}, 32'(a.idex_bubble), 32'(e.idex_bubble));
      cmp({p, ".pipe_hold"},   32'(a.pipe_hold),   32'(e.pipe_hold));
      cmp({p, ".fwd_a_sel"},   32'(a.fa),          32'(e.fa));
      cmp({p, ".fwd_b_sel"},   32'(a.fb),          32'(e.fb));
      cmp({p, ".mdu_busy"},    32'(a.busy),        32'(e.busy));
      cmp({p, ".mdu_err"},     32'(a.err),         32'(e.err));
      cmp({p, ".stall_cnt"},   (k == 0) ? 32'(if0.stall_cnt) : 32'(if1.stall_cnt), 32'(m_scnt[k]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    rs_ID = 0; rt_ID = 0; id_uses_rs = 0; id_uses_rt = 0; id_mdu = 0; id_reads_hilo = 0;
    WriteDestination_EX = 0; WriteDestination_MEM = 0; WriteDestination_WB = 0;
    ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0; ex_load = 0;
    mdu_start_EX = 0; branch_taken_ID = 0; mem_busy = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_load = 1; ex_reg_write = 1; WriteDestination_EX = 5; rs_ID = 5; id_uses_rs = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    ex_reg_write = 1; WriteDestination_EX = 3; rs_ID = 3;
    #8;
    cmp("reset pc_le", 32'(if1.pc_le), 0);
    cmp("reset ifid_le", 32'(if1.ifid_le), 0);
    cmp("reset fwd_a_sel", 32'(if1.fwd_a_sel), 0);
    @(posedge clk);
    cyc();
    reset = 1'b1;
    idle();

    // mult/div followed by mfhi: stall for the whole busy window
    mdu_start_EX = 1;
    #2;
    cmp("mdu start busy", 32'(if1.mdu_busy), 0);
    cmp("mdu start pc_le", 32'(if1.pc_le), 1);
    for (int i = 0; i < MDU_LAT; i++) begin
      cyc();
      mdu_start_EX = 0; id_reads_hilo = 1;
      #2;
      cmp("mfhi stall busy", 32'(if1.mdu_busy), 1);
      cmp("mfhi stall pc_le", 32'(if1.pc_le), 0);
      cmp("mfhi stall bubble", 32'(if1.idex_bubble), 1);
    end
    cyc();
    #2;
    cmp("mdu done busy", 32'(if1.mdu_busy), 0);
    cmp("mdu done pc_le", 32'(if1.pc_le), 1);
    cmp("mdu stall_cnt", 32'(if1.stall_cnt), 4);
    idle();

    // load-use: one bubble, then the load result comes from MEM
    cyc();
    set_load_use();
    #2;
    cmp("load-use pc_le", 32'(if1.pc_le), 0);
    cmp("load-use bubble", 32'(if1.idex_bubble), 1);
    cyc();
    ex_load = 0; ex_reg_write = 0; WriteDestination_EX = 0;
    mem_reg_write = 1; WriteDestination_MEM = 5;
    #2;
    cmp("load-use fwd_a", 32'(if1.fwd_a_sel), 2);
    cmp("load-use release pc_le", 32'(if1.pc_le), 1);
    idle();

    // forwarding priority
    cyc();
    ex_reg_write = 1; WriteDestination_EX = 7; mem_reg_write = 1; WriteDestination_MEM = 7;
    wb_reg_write = 1; WriteDestination_WB = 7; rt_ID = 7; id_uses_rt = 1;
    #2;
    cmp("fwd EX over MEM", 32'(if1.fwd_b_sel), 1);
    cyc();
    WriteDestination_EX = 0; WriteDestination_MEM = 0; WriteDestination_WB = 0; rt_ID = 0;
    #2;
    cmp("fwd dest zero", 32'(if1.fwd_b_sel), 0);
    cyc();
    WriteDestination_WB = 9; rt_ID = 9; rs_ID = 9;
    #2;
    cmp("fwd WB", 32'(if1.fwd_b_sel), 3);
    cyc();
    ex_load = 1; id_uses_rt = 0; WriteDestination_EX = 7; WriteDestination_MEM = 7; rt_ID = 7; rs_ID = 7;
    #2;
    cmp("fwd skip EX load", 32'(if1.fwd_b_sel), 2);
    cyc();
    mem_reg_write = 0; ex_load = 0; WriteDestination_EX = 6; WriteDestination_WB = 7;
    #2;
    cmp("fwd WB behind EX mismatch", 32'(if1.fwd_a_sel), 3);
    idle();

    // memory wait on top of a load-use hazard
    for (int i = 0; i < 3; i++) begin
      cyc();
      set_load_use(); mem_busy = 1;
      #2;
      cmp("mem_busy hold", 32'(if1.pipe_hold), 1);
      cmp("mem_busy bubble", 32'(if1.idex_bubble), 0);
      cmp("mem_busy pc_le", 32'(if1.pc_le), 0);
    end
    cyc();
    mem_busy = 0;
    #2;
    cmp("after hold bubble", 32'(if1.idex_bubble), 1);
    cmp("after hold pipe_hold", 32'(if1.pipe_hold), 0);
    idle();

    // a start during a memory hold does not launch the MDU
    cyc();
    mdu_start_EX = 1; mem_busy = 1;
    cyc();
    idle();
    #2;
    cmp("start under hold", 32'(if1.mdu_busy), 0);

    // taken branch flush only without a delay slot and without a stall
    cyc();
    branch_taken_ID = 1;
    #2;
    cmp("flush no delay slot", 32'(if0.ifid_flush), 1);
    cmp("flush with delay slot", 32'(if1.ifid_flush), 0);
    cyc();
    set_load_use();
    #2;
    cmp("flush blocked by stall", 32'(if0.ifid_flush), 0);
    cyc();
    ex_load = 0; mem_busy = 1;
    #2;
    cmp("flush blocked by hold", 32'(if0.ifid_flush), 0);
    idle();

    // mdu hazard on the start cycle itself, then a protocol error
    cyc();
    mdu_start_EX = 1; id_mdu = 1;
    #2;
    cmp("mdu hazard on start", 32'(if1.pc_le), 0);
    cyc();
    id_mdu = 0;
    #2;
    cmp("second start busy", 32'(if1.mdu_busy), 1);
    cmp("err not yet", 32'(if1.mdu_err), 0);
    cyc();
    mdu_start_EX = 0;
    #2;
    cmp("err sticky", 32'(if1.mdu_err), 1);
    for (int i = 0; i < 4; i++) cyc();
    #2;
    cmp("err stays after busy", 32'(if1.mdu_err), 1);
    cmp("busy ended", 32'(if1.mdu_busy), 0);

    // long memory wait saturates the narrow counter
    for (int i = 0; i < 10; i++) begin
      cyc();
      mem_busy = 1;
    end
    cyc();
    mem_busy = 0;
    #2;
    cmp("stall_cnt saturate", 32'(if0.stall_cnt), 7);

    // reset in the middle of an MDU operation
    cyc();
    mdu_start_EX = 1;
    cyc();
    mdu_start_EX = 0;
    cyc();
    id_reads_hilo = 1; ex_reg_write = 1; WriteDestination_EX = 4; rs_ID = 4;
    #2;
    cmp("pre-reset busy", 32'(if1.mdu_busy), 1);
    reset = 1'b0;
    #1;
    cmp("async reset pc_le", 32'(if1.pc_le), 0);
    cmp("async reset ifid_le", 32'(if1.ifid_le), 0);
    cmp("async reset bubble", 32'(if1.idex_bubble), 0);
    cmp("async reset fwd_a", 32'(if1.fwd_a_sel), 0);
    cmp("async reset busy", 32'(if1.mdu_busy), 0);
    cmp("async reset err", 32'(if1.mdu_err), 0);
    cmp("async reset stall_cnt", 32'(if1.stall_cnt), 0);
    cyc();
    reset = 1'b1;
    #2;
    cmp("post-reset busy", 32'(if1.mdu_busy), 0);
    cmp("post-reset pc_le", 32'(if1.pc_le), 1);
    cmp("post-reset stall_cnt", 32'(if1.stall_cnt), 0);
    cmp("post-reset fwd_a", 32'(if1.fwd_a_sel), 1);
    idle();
    cyc();
    cyc();
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
